gate_motor_sequencer: RTL and testbench
=======================================

// Module: gate_motor_sequencer
// PURPOSE
//  Sequences the gate motor: drives abrir_o/fechar_o from a push button, two limit
//  switches (fcc_i closed, fca_i open) and a photocell (obst_i). Adds auto-close,
//  obstacle reversal, reversal dead time and travel-timeout fault on top of the basic
//  one-button open/close gate controller. Sits between board I/O and the motor driver.
// PARAMETERS
//  HOLD_CYCLES  50   cycles gate stays open before auto-close (when enabled)
//  TRAVEL_MAX   200  max cycles motor may run in one direction before fault
//  REV_DELAY    4    dead-time cycles, both outputs low, on closing->opening reversal
// PORTS
//  clk_i     in   1  clock; single clock domain
//  rst_i     in   1  reset, synchronous, active-high
//  btn_i     in   1  push button, level; rising edge detected internally
//  fcc_i     in   1  limit switch, gate fully closed
//  fca_i     in   1  limit switch, gate fully open
//  obst_i    in   1  photocell, 1 = obstacle in gate path
//  abrir_o   out  1  motor open command
//  fechar_o  out  1  motor close command
//  state_o   out  3  current state code (debug)
//  fault_o   out  1  1 while in FALHA
// BEHAVIOUR
//  - btn_rise = btn_i & ~btn_q; btn_q registered, reset 0. All inputs sampled on clk_i rise.
//  - States/codes: INIT=0 FECHADO=1 ABRINDO=2 ABERTO=3 FECHANDO=4 PARADO=5 PAUSA=6 FALHA=7.
//  - Outputs are a Moore decode of the state register: abrir_o=1 only in ABRINDO,
//    fechar_o=1 only in FECHANDO, fault_o=1 only in FALHA. Never both motor outputs high.
//  - Reset: state=INIT, all outputs 0, all counters 0, btn_q=0. Reset mid-travel drops
//    the motor in the same edge.
//  - Latency: event sampled at edge N -> new state and outputs valid after edge N.
//  - fca_i & fcc_i both 1 in any state other than FALHA -> FALHA (top priority).
//  - INIT (one cycle): fcc_i -> FECHADO; else fca_i -> ABERTO; else -> PARADO.
//  - FECHADO: btn_rise -> ABRINDO.
//  - ABRINDO: priority fca_i -> ABERTO; btn_rise -> PARADO; travel timeout -> FALHA.
//  - ABERTO: btn_rise -> FECHANDO. Hold timer counts while obst_i=0; obst_i=1 clears it.
//  - FECHANDO: priority fcc_i -> FECHADO; obst_i -> PAUSA; btn_rise -> PAUSA;
//    travel timeout -> FALHA.
//  - PAUSA: outputs 0, counts REV_DELAY cycles, then -> ABRINDO; btn_rise ignored.
//  - PARADO: btn_rise -> FECHANDO.
//  - FALHA: outputs 0; exits only via rst_i.
//  - Travel counter: width $clog2(TRAVEL_MAX+1); cleared on entry to ABRINDO/FECHANDO;
//    increments each cycle there; timeout when the motor has been on TRAVEL_MAX cycles
//    without reaching a limit switch. A limit switch on that same cycle wins.
//  - Hold counter: width $clog2(HOLD_CYCLES+1); cleared on entry to ABERTO.
// CONFIGURATION
//  GATE_AUTO_CLOSE_EN defined: in ABERTO, when the hold counter reaches HOLD_CYCLES
//    with obst_i=0, -> FECHANDO. btn_rise on the same cycle also -> FECHANDO.
//  Undefined: hold counter and its logic are not built; ABERTO leaves only on btn_rise
//    or the illegal-sensor fault.
// TESTING (HOLD_CYCLES=8, TRAVEL_MAX=16, REV_DELAY=2, GATE_AUTO_CLOSE_EN defined)
//  - rst_i high with fcc_i=1, then release -> state_o 0 then 1. btn_i high 1 cycle ->
//    abrir_o=1 after the next edge. fca_i=1 at cycle 6 -> abrir_o=0, state_o=3.
//  - Hold in ABERTO with obst_i=0 -> after 8 cycles fechar_o=1. obst_i=1 pulse at
//    cycle 5 restarts the count (close after 8 more cycles).
//  - In FECHANDO, obst_i=1 -> fechar_o=0 and state_o=6 for 2 cycles, then abrir_o=1.
//    Same sequence for btn_rise while closing.
//  - In ABRINDO with no limit switches for 16 cycles -> state_o=7, fault_o=1, outputs 0.
//    btn_i toggles have no effect until rst_i.
//  - btn_rise mid-ABRINDO -> PARADO, outputs 0; next btn_rise -> fechar_o=1.
//    fca_i=fcc_i=1 while opening -> FALHA.
//  - Held btn_i (20 cycles high) -> exactly one transition. Macro undefined ->
//    ABERTO stays 50+ cycles with no motor output.

Source files
------------

// File: rtl/gate_motor_sequencer.sv
// Gate motor sequencer: one-button open/close with auto-close, obstacle reversal, dead time and
// travel-timeout fault. Optional auto-close enabled by defining GATE_AUTO_CLOSE_EN.
module gate_motor_sequencer #(
    parameter int unsigned HOLD_CYCLES = 50,
    parameter int unsigned TRAVEL_MAX  = 200,
    parameter int unsigned REV_DELAY   = 4
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       btn_i,
    input  logic       fcc_i,
    input  logic       fca_i,
    input  logic       obst_i,
    output logic       abrir_o,
    output logic       fechar_o,
    output logic [2:0] state_o,
    output logic       fault_o
);

    localparam int unsigned TravelW = $clog2(TRAVEL_MAX + 1);
    localparam int unsigned RevW    = (REV_DELAY < 1) ? 1 : $clog2(REV_DELAY + 1);

    typedef enum logic [2:0] {
        StInit     = 3'd0,
        StFechado  = 3'd1,
        StAbrindo  = 3'd2,
        StAberto   = 3'd3,
        StFechando = 3'd4,
        StParado   = 3'd5,
        StPausa    = 3'd6,
        StFalha    = 3'd7
    } state_e;

    state_e               state_q, state_d;
    logic                 btn_q;
    logic                 btn_rise;
    logic [TravelW-1:0]   travel_q, travel_d;
    logic [RevW-1:0]      rev_q, rev_d;
    logic                 travel_done;
    logic                 rev_done;

`ifdef GATE_AUTO_CLOSE_EN
    localparam int unsigned HoldW = $clog2(HOLD_CYCLES + 1);
    logic [HoldW-1:0]     hold_q, hold_d;
    logic                 hold_done;
`endif

    always_comb begin
        btn_rise    = btn_i & ~btn_q;
        // The edge that sees the last-allowed count is the TRAVEL_MAX-th motor-on cycle.
        travel_done = (travel_q == TravelW'(TRAVEL_MAX - 1));
        rev_done    = (rev_q == RevW'(REV_DELAY - 1));
`ifdef GATE_AUTO_CLOSE_EN
        hold_done   = (hold_q == HoldW'(HOLD_CYCLES - 1));
`endif
        state_d = state_q;
        if (fca_i && fcc_i && (state_q != StFalha)) begin
            state_d = StFalha;
        end else begin
            unique case (state_q)
                StInit: begin
                    if (fcc_i)      state_d = StFechado;
                    else if (fca_i) state_d = StAberto;
                    else            state_d = StParado;
                end
                StFechado: begin
                    if (btn_rise) state_d = StAbrindo;
                end
                StAbrindo: begin
                    if (fca_i)            state_d = StAberto;
                    else if (btn_rise)    state_d = StParado;
                    else if (travel_done) state_d = StFalha;
                end
                StAberto: begin
`ifdef GATE_AUTO_CLOSE_EN
                    if (btn_rise || (!obst_i && hold_done)) state_d = StFechando;
`else
                    if (btn_rise) state_d = StFechando;
`endif
                end
                StFechando: begin
                    if (fcc_i)                  state_d = StFechado;
                    else if (obst_i || btn_rise) state_d = StPausa;
                    else if (travel_done)       state_d = StFalha;
                end
                StParado: begin
                    if (btn_rise) state_d = StFechando;
                end
                StPausa: begin
                    if (rev_done) state_d = StAbrindo;
                end
                StFalha: state_d = StFalha;
                default: state_d = StFalha;
            endcase
        end

        // Counters run only while the state holds; any transition clears them.
        travel_d = '0;
        if ((state_d == state_q) && ((state_q == StAbrindo) || (state_q == StFechando))) begin
            travel_d = travel_q + TravelW'(1);
        end
        rev_d = '0;
        if ((state_d == state_q) && (state_q == StPausa)) begin
            rev_d = rev_q + RevW'(1);
        end
`ifdef GATE_AUTO_CLOSE_EN
        hold_d = '0;
        if ((state_d == state_q) && (state_q == StAberto) && !obst_i) begin
            hold_d = hold_q + HoldW'(1);
        end
`endif
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= StInit;
            btn_q    <= 1'b0;
            travel_q <= '0;
            rev_q    <= '0;
`ifdef GATE_AUTO_CLOSE_EN
            hold_q   <= '0;
`endif
            abrir_o  <= 1'b0;
            fechar_o <= 1'b0;
            fault_o  <= 1'b0;
        end else begin
            state_q  <= state_d;
            btn_q    <= btn_i;
            travel_q <= travel_d;
            rev_q    <= rev_d;
`ifdef GATE_AUTO_CLOSE_EN
            hold_q   <= hold_d;
`endif
            abrir_o  <= (state_d == StAbrindo);
            fechar_o <= (state_d == StFechando);
            fault_o  <= (state_d == StFalha);
        end
    end

    assign state_o = state_q;

endmodule

// File: tb/tb_gate_motor_sequencer.sv
// Self-checking bench for gate_motor_sequencer: directed scenarios plus randomized stimulus
// against a time-in-state reference model. Follows GATE_AUTO_CLOSE_EN like the design.
module tb_gate_motor_sequencer;

    localparam int HOLD = 8;
    localparam int TRAV = 16;
    localparam int REV  = 2;

    // {state, abrir, fechar, fault}
    localparam logic [5:0] O_INIT = 6'b000_000;
    localparam logic [5:0] O_FECH = 6'b001_000;
    localparam logic [5:0] O_ABR  = 6'b010_100;
    localparam logic [5:0] O_ABE  = 6'b011_000;
    localparam logic [5:0] O_FCH  = 6'b100_010;
    localparam logic [5:0] O_PAR  = 6'b101_000;
    localparam logic [5:0] O_PAU  = 6'b110_000;
    localparam logic [5:0] O_FAL  = 6'b111_001;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       btn = 1'b0;
    logic       fcc = 1'b0;
    logic       fca = 1'b0;
    logic       obst = 1'b0;
    logic       abrir, fechar, fault;
    logic [2:0] state;
    logic [5:0] obs;

    int checks = 0;
    int failures = 0;

    // Reference model: named state, cycles spent in it, obstacle-free cycles while open.
    int m_state = 0;
    int m_on = 0;
    int m_hold = 0;
    bit m_prev = 1'b0;

    gate_motor_sequencer #(
        .HOLD_CYCLES(HOLD),
        .TRAVEL_MAX (TRAV),
        .REV_DELAY  (REV)
    ) dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .btn_i   (btn),
        .fcc_i   (fcc),
        .fca_i   (fca),
        .obst_i  (obst),
        .abrir_o (abrir),
        .fechar_o(fechar),
        .state_o (state),
        .fault_o (fault)
    );

    always #5 clk = ~clk;
    assign obs = {state, abrir, fechar, fault};

    function automatic logic [5:0] model_out();
        return {3'(m_state), m_state == 2, m_state == 4, m_state == 7};
    endfunction

    task automatic model_edge(input bit r, input bit b, input bit c, input bit a, input bit o);
        int nxt;
        bit rise;
        if (r) begin
            m_state = 0; m_on = 0; m_hold = 0; m_prev = 1'b0;
            return;
        end
        rise = b && !m_prev;
        m_prev = b;
        nxt = m_state;
        if (m_state != 7 && a && c) nxt = 7;
        else begin
            case (m_state)
                0: nxt = c ? 1 : (a ? 3 : 5);
                1: if (rise) nxt = 2;
                2: begin
                    if (a) nxt = 3;
                    else if (rise) nxt = 5;
                    else if (m_on + 1 >= TRAV) nxt = 7;
                end
                3: begin
                    if (rise) nxt = 4;
`ifdef GATE_AUTO_CLOSE_EN
                    else if (!o && m_hold + 1 >= HOLD) nxt = 4;
`endif
                end
                4: begin
                    if (c) nxt = 1;
                    else if (o || rise) nxt = 6;
                    else if (m_on + 1 >= TRAV) nxt = 7;
                end
                5: if (rise) nxt = 4;
                6: if (m_on + 1 >= REV) nxt = 2;
                default: nxt = 7;
            endcase
        end
        if (nxt != m_state) begin
            m_on = 0; m_hold = 0;
        end else begin
            m_on++;
            m_hold = o ? 0 : m_hold + 1;
        end
        m_state = nxt;
    endtask

    task automatic step(input bit b, input bit c, input bit a, input bit o);
        btn = b; fcc = c; fca = a; obst = o;
        @(posedge clk);
        model_edge(rst, b, c, a, o);
        #1;
    endtask

    task automatic do_reset(input bit c, input bit a);
        rst = 1'b1;
        step(1'b0, c, a, 1'b0);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset(1'b1, 1'b0);
        checks++;
        if (obs !== O_INIT) begin
            failures++; $display("FAIL reset got=%b want=%b", obs, O_INIT);
        end
        step(0, 1, 0, 0);
        checks++;
        if (obs !== O_FECH) begin
            failures++; $display("FAIL init_to_fechado got=%b want=%b", obs, O_FECH);
        end
    endtask

    task automatic test_open();
        step(1, 1, 0, 0);
        checks++;
        if (obs !== O_ABR) begin
            failures++; $display("FAIL open_start got=%b want=%b", obs, O_ABR);
        end
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0);
        checks++;
        if (obs !== O_ABR) begin
            failures++; $display("FAIL opening_hold got=%b want=%b", obs, O_ABR);
        end
        step(0, 0, 1, 0);
        checks++;
        if (obs !== O_ABE) begin
            failures++; $display("FAIL open_limit got=%b want=%b", obs, O_ABE);
        end
    endtask

    task automatic test_auto_close();
`ifdef GATE_AUTO_CLOSE_EN
        for (int i = 0; i < HOLD - 1; i++) step(0, 0, 1, 0);
        checks++;
        if (obs !== O_ABE) begin
            failures++; $display("FAIL hold_early got=%b want=%b", obs, O_ABE);
        end
        step(0, 0, 1, 0);
        checks++;
        if (obs !== O_FCH) begin
            failures++; $display("FAIL auto_close got=%b want=%b", obs, O_FCH);
        end
`else
        for (int i = 0; i < 60; i++) begin
            step(0, 0, 1, 0);
            checks++;
            if (obs !== O_ABE) begin
                failures++; $display("FAIL no_auto_close cyc=%0d got=%b want=%b", i, obs, O_ABE);
            end
        end
        step(1, 0, 1, 0);
        checks++;
        if (obs !== O_FCH) begin
            failures++; $display("FAIL btn_close got=%b want=%b", obs, O_FCH);
        end
`endif
    endtask

    task automatic test_reversal_obst();
        step(0, 0, 0, 1);
        checks++;
        if (obs !== O_PAU) begin
            failures++; $display("FAIL obst_pause got=%b want=%b", obs, O_PAU);
        end
        step(0, 0, 0, 0);
        checks++;
        if (obs !== O_PAU) begin
            failures++; $display("FAIL obst_dead_time got=%b want=%b", obs, O_PAU);
        end
        step(0, 0, 0, 0);
        checks++;
        if (obs !== O_ABR) begin
            failures++; $display("FAIL obst_reopen got=%b want=%b", obs, O_ABR);
        end
        step(0, 0, 1, 0);
    endtask

    task automatic test_hold_restart();
`ifdef GATE_AUTO_CLOSE_EN
        for (int i = 0; i < 4; i++) step(0, 0, 1, 0);
        step(0, 0, 1, 1);
        for (int i = 0; i < HOLD - 1; i++) step(0, 0, 1, 0);
        checks++;
        if (obs !== O_ABE) begin
            failures++; $display("FAIL hold_restart_early got=%b want=%b", obs, O_ABE);
        end
        step(0, 0, 1, 0);
        checks++;
        if (obs !== O_FCH) begin
            failures++; $display("FAIL hold_restart_close got=%b want=%b", obs, O_FCH);
        end
`else
        step(1, 0, 1, 0);
        step(0, 0, 0, 0);
        checks++;
        if (obs !== O_FCH) begin
            failures++; $display("FAIL btn_close2 got=%b want=%b", obs, O_FCH);
        end
`endif
    endtask

    task automatic test_reversal_btn();
        step(1, 0, 0, 0);
        checks++;
        if (obs !== O_PAU) begin
            failures++; $display("FAIL btn_pause got=%b want=%b", obs, O_PAU);
        end
        step(0, 0, 0, 0);
        // A fresh press at the end of the dead time must not disturb the reversal.
        step(1, 0, 0, 0);
        checks++;
        if (obs !== O_ABR) begin
            failures++; $display("FAIL btn_reopen got=%b want=%b", obs, O_ABR);
        end
    endtask

    task automatic test_timeout();
        do_reset(1'b1, 1'b0);
        step(0, 1, 0, 0);
        step(1, 1, 0, 0);
        for (int i = 0; i < TRAV - 1; i++) step(0, 0, 0, 0);
        checks++;
        if (obs !== O_ABR) begin
            failures++; $display("FAIL timeout_early got=%b want=%b", obs, O_ABR);
        end
        step(0, 0, 0, 0);
        checks++;
        if (obs !== O_FAL) begin
            failures++; $display("FAIL timeout got=%b want=%b", obs, O_FAL);
        end
        for (int i = 0; i < 6; i++) begin
            step(i[0] == 1'b0, i == 2, i == 4, 0);
            checks++;
            if (obs !== O_FAL) begin
                failures++; $display("FAIL fault_sticky cyc=%0d got=%b want=%b", i, obs, O_FAL);
            end
        end
    endtask

    task automatic test_stop_and_illegal();
        do_reset(1'b1, 1'b0);
        step(0, 1, 0, 0);
        step(1, 1, 0, 0);
        step(0, 0, 0, 0);
        step(1, 0, 0, 0);
        checks++;
        if (obs !== O_PAR) begin
            failures++; $display("FAIL stop got=%b want=%b", obs, O_PAR);
        end
        step(0, 0, 0, 0);
        step(1, 0, 0, 0);
        checks++;
        if (obs !== O_FCH) begin
            failures++; $display("FAIL stop_close got=%b want=%b", obs, O_FCH);
        end
        step(0, 1, 0, 0);
        checks++;
        if (obs !== O_FECH) begin
            failures++; $display("FAIL close_limit got=%b want=%b", obs, O_FECH);
        end
        step(1, 1, 0, 0);
        step(0, 0, 0, 0);
        step(0, 1, 1, 0);
        checks++;
        if (obs !== O_FAL) begin
            failures++; $display("FAIL illegal_sensors got=%b want=%b", obs, O_FAL);
        end
    endtask

    task automatic test_held_button();
        int trans;
        logic [2:0] prev;
        do_reset(1'b0, 1'b0);
        step(0, 0, 0, 0);
        checks++;
        if (obs !== O_PAR) begin
            failures++; $display("FAIL init_to_parado got=%b want=%b", obs, O_PAR);
        end
        trans = 0;
        for (int i = 0; i < 20; i++) begin
            prev = state;
            step(1, i >= 5, 0, 0);
            if (state !== prev) trans++;
        end
        checks++;
        if (trans != 2 || obs !== O_FECH) begin
            failures++;
            $display("FAIL held_button trans=%0d got=%b want trans=2 %b", trans, obs, O_FECH);
        end
    endtask

    task automatic test_random();
        do_reset(1'b0, 1'b0);
        for (int i = 0; i < 600; i++) begin
            rst = ($urandom_range(0, 63) == 0) || (m_state == 7 && $urandom_range(0, 3) == 0);
            step($urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0,
                 $urandom_range(0, 9) == 0, $urandom_range(0, 5) == 0);
            checks++;
            if (obs !== model_out()) begin
                failures++; $display("FAIL random cyc=%0d got=%b want=%b", i, obs, model_out());
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_open();
        test_auto_close();
        test_reversal_obst();
        test_hold_restart();
        test_reversal_btn();
        test_timeout();
        test_stop_and_illegal();
        test_held_button();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
